// File: rtl/i2s_sched_unit.sv
// Purpose: I2S playback scheduler: start/stop FSM with guard hold, sample-rate ticks, one-entry stereo buffer.
// Latency: play_out/tick_out/audio/underrun are registered (1 cycle); sample_ready_out is combinational.
// Backpressure: sample_ready_out = !buf_full; upstream holds its sample until the serializer drains the buffer.
// Optional: define I2S_SCHED_UNDERRUN_CNT_EN to add the saturating 16-bit underrun_cnt_out port.
module i2s_sched_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    input  logic        stop_in,
    input  logic [15:0] div_in,
    input  logic        sample_valid_in,
    input  logic [23:0] sample0_in,
    input  logic [23:0] sample1_in,
    output logic        sample_ready_out,
    input  logic        req_in,
    output logic        play_out,
    output logic        tick_out,
    output logic [23:0] audio0_out,
    output logic [23:0] audio1_out,
    output logic        underrun_out,
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
    output logic [15:0] underrun_cnt_out,
`endif
    output logic        busy_out
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [8:0] GUARD_LOAD = 9'd384;

    state_t      state;
    logic [8:0]  guard;
    logic        pend_vld;
    logic        pend_stop;
    logic [15:0] period;
    logic [15:0] tick_cnt;
    logic        buf_full;
    logic [23:0] buf0;
    logic [23:0] buf1;

    logic        eff_start;
    logic        eff_stop;
    logic        go_run;
    logic        go_idle;
    logic        accept;
    logic        take;

    // Resolve the request seen this cycle: live inputs override a pending one, stop beats start.
    always_comb begin
        eff_start = 1'b0;
        eff_stop  = 1'b0;
        if (start_in || stop_in) begin
            eff_stop  = stop_in;
            eff_start = start_in & ~stop_in;
        end else if (pend_vld) begin
            eff_stop  = pend_stop;
            eff_start = ~pend_stop;
        end
    end

    assign go_run           = (state == IDLE) && (guard == 9'd0) && eff_start;
    assign go_idle          = (state == RUN)  && (guard == 9'd0) && eff_stop;
    assign sample_ready_out = ~buf_full;
    assign accept           = sample_valid_in & ~buf_full;
    assign take             = (state == RUN) && req_in && buf_full && !go_idle;
    assign busy_out         = (state != IDLE) || (guard != 9'd0);

    // Control FSM: play state, guard hold, pending request, period capture and tick generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            play_out  <= 1'b0;
            guard     <= 9'd0;
            pend_vld  <= 1'b0;
            pend_stop <= 1'b0;
            period    <= 16'd2;
            tick_cnt  <= 16'd0;
            tick_out  <= 1'b0;
        end else begin
            // Requests arriving during the hold are remembered; the last one wins.
            if (guard != 9'd0) begin
                if (start_in || stop_in) begin
                    pend_vld  <= 1'b1;
                    pend_stop <= stop_in;
                end
            end else begin
                pend_vld <= 1'b0;
            end

            if (go_run || go_idle) begin
                guard <= GUARD_LOAD;
            end else if (guard != 9'd0) begin
                guard <= guard - 9'd1;
            end

            if (go_run) begin
                state    <= RUN;
                play_out <= 1'b1;
                period   <= (div_in < 16'd2) ? 16'd2 : div_in;
                tick_cnt <= 16'd0;
                tick_out <= 1'b0;
            end else if (go_idle) begin
                state    <= IDLE;
                play_out <= 1'b0;
                tick_cnt <= 16'd0;
                tick_out <= 1'b0;
            end else if (state == RUN) begin
                if (tick_cnt == period - 16'd1) begin
                    tick_cnt <= 16'd0;
                    tick_out <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 16'd1;
                    tick_out <= 1'b0;
                end
            end else begin
                tick_out <= 1'b0;
            end
        end
    end

    // Sample buffer and serializer data: fill any time, drain on request in RUN, flush on stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full     <= 1'b0;
            buf0         <= 24'd0;
            buf1         <= 24'd0;
            audio0_out   <= 24'd0;
            audio1_out   <= 24'd0;
            underrun_out <= 1'b0;
        end else begin
            underrun_out <= 1'b0;
            if (accept) begin
                buf0 <= sample0_in;
                buf1 <= sample1_in;
            end
            if (go_idle) begin
                buf_full   <= 1'b0;
                audio0_out <= 24'd0;
                audio1_out <= 24'd0;
            end else begin
                if (take) begin
                    buf_full <= 1'b0;
                end else if (accept) begin
                    buf_full <= 1'b1;
                end
                if ((state == RUN) && req_in) begin
                    // An empty buffer yields silence, never the sample arriving this cycle.
                    audio0_out   <= buf_full ? buf0 : 24'd0;
                    audio1_out   <= buf_full ? buf1 : 24'd0;
                    underrun_out <= ~buf_full;
                end
            end
        end
    end

`ifdef I2S_SCHED_UNDERRUN_CNT_EN
    // Saturating underrun count; survives stop, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_out <= 16'd0;
        end else if (underrun_out && (underrun_cnt_out != 16'hFFFF)) begin
            underrun_cnt_out <= underrun_cnt_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_sched_unit.sv
// Directed bench for i2s_sched_unit: start/stop with guard hold, tick timing, buffer drain, underrun, reset.
// Outputs are sampled on the falling clock edge; inputs change there too.
// Expected values are hand-derived constants.
module tb_i2s_sched_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_in;
    logic        stop_in;
    logic [15:0] div_in;
    logic        sample_valid_in;
    logic [23:0] sample0_in;
    logic [23:0] sample1_in;
    logic        sample_ready_out;
    logic        req_in;
    logic        play_out;
    logic        tick_out;
    logic [23:0] audio0_out;
    logic [23:0] audio1_out;
    logic        underrun_out;
    logic        busy_out;
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_out;
`endif

    int errors = 0;
    int checks = 0;
    int ticks_seen = 0;

    i2s_sched_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_in         (start_in),
        .stop_in          (stop_in),
        .div_in           (div_in),
        .sample_valid_in  (sample_valid_in),
        .sample0_in       (sample0_in),
        .sample1_in       (sample1_in),
        .sample_ready_out (sample_ready_out),
        .req_in           (req_in),
        .play_out         (play_out),
        .tick_out         (tick_out),
        .audio0_out       (audio0_out),
        .audio1_out       (audio1_out),
        .underrun_out     (underrun_out),
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
        .underrun_cnt_out (underrun_cnt_out),
`endif
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start_in = 1'b0;
        stop_in = 1'b0;
        div_in = 16'd100;
        sample_valid_in = 1'b0;
        sample0_in = 24'd0;
        sample1_in = 24'd0;
        req_in = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_play", play_out, 0);
        chk("rst_tick", tick_out, 0);
        chk("rst_audio0", audio0_out, 0);
        chk("rst_audio1", audio1_out, 0);
        chk("rst_underrun", underrun_out, 0);
        chk("rst_ready", sample_ready_out, 1);
        chk("rst_busy", busy_out, 0);
        rst_n = 1'b1;
        step();

        // One-cycle start with P=100, then stop held 10 cycles inside the guard window
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("start_play", play_out, 1);
        chk("start_busy", busy_out, 1);
        stop_in = 1'b1;
        for (int k = 1; k <= 770; k++) begin
            step();
            if (k == 10) stop_in = 1'b0;
            if (tick_out) ticks_seen++;
            if (k == 99)  chk("tick_k99", tick_out, 0);
            if (k == 100) chk("tick_k100", tick_out, 1);
            if (k == 101) chk("tick_k101", tick_out, 0);
            if (k == 200) chk("tick_k200", tick_out, 1);
            if (k == 300) chk("tick_k300", tick_out, 1);
            if (k == 384) chk("play_hold_k384", play_out, 1);
            if (k == 385) chk("play_fall_k385", play_out, 0);
            if (k == 385) chk("busy_guard_k385", busy_out, 1);
            if (k == 400) chk("tick_stopped_k400", tick_out, 0);
            if (k == 770) chk("busy_clear_k770", busy_out, 0);
        end
        chk("tick_count", ticks_seen, 3);

        // start and stop together in IDLE: no transition
        start_in = 1'b1;
        stop_in = 1'b1;
        step();
        start_in = 1'b0;
        stop_in = 1'b0;
        step();
        step();
        chk("both_play", play_out, 0);
        chk("both_busy", busy_out, 0);

        // Pre-fill in IDLE; req ignored in IDLE
        sample_valid_in = 1'b1;
        sample0_in = 24'h123456;
        sample1_in = 24'hABCDEF;
        step();
        sample_valid_in = 1'b0;
        chk("prefill_ready", sample_ready_out, 0);
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        chk("idle_req_audio0", audio0_out, 0);
        chk("idle_req_underrun", underrun_out, 0);
        chk("idle_req_ready", sample_ready_out, 0);

        // Start with div_in=0 (clamped to period 2)
        div_in = 16'd0;
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("p2_play", play_out, 1);
        step();
        chk("p2_tick_k1", tick_out, 0);
        step();
        chk("p2_tick_k2", tick_out, 1);
        step();
        chk("p2_tick_k3", tick_out, 0);
        step();
        chk("p2_tick_k4", tick_out, 1);

        // Drain the pre-filled sample
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        chk("drain_audio0", audio0_out, 32'h123456);
        chk("drain_audio1", audio1_out, 32'hABCDEF);
        chk("drain_ready", sample_ready_out, 1);
        chk("drain_underrun", underrun_out, 0);

        // Request with an empty buffer
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        chk("underrun_audio0", audio0_out, 0);
        chk("underrun_audio1", audio1_out, 0);
        chk("underrun_pulse", underrun_out, 1);
        step();
        chk("underrun_one_cycle", underrun_out, 0);
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
        chk("underrun_cnt", underrun_cnt_out, 1);
`endif

        // Load a fresh sample into the outputs, then reset mid-RUN
        sample_valid_in = 1'b1;
        sample0_in = 24'h0F0F0F;
        sample1_in = 24'h00FF00;
        step();
        sample_valid_in = 1'b0;
        req_in = 1'b1;
        step();
        req_in = 1'b0;
        chk("run2_audio0", audio0_out, 32'h0F0F0F);
        chk("run2_tick_k9", tick_out, 0);
        step();
        chk("run2_tick_k10", tick_out, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_play", play_out, 0);
        chk("async_rst_tick", tick_out, 0);
        chk("async_rst_audio0", audio0_out, 0);
        chk("async_rst_audio1", audio1_out, 0);
        chk("async_rst_busy", busy_out, 0);
        step();
        rst_n = 1'b1;
        step();

        // No guard hold after reset: start is honoured immediately
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("post_rst_start", play_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
